product_accumulator: RTL

- Signed accumulation stage that sits directly downstream of the signed N-bit multiplier and consumes its 2N-bit product P.
- Sums a run of LEN products, or a shorter run that ends on in_last, into a guard-extended accumulator with saturation.
- Presents the result on a valid/ready output and holds it until the consumer accepts it.
- Feeds the result-collection/display stage of the datapath.

---
 rtl/mult_pkg.sv | 9 +
 rtl/product_accumulator_if.sv | 20 ++
 rtl/sat_add.sv | 14 +
 rtl/product_accumulator.sv | 59 +++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and accumulator width helper for the multiplier datapath.
//   ACCUM - collecting products, HOLD - result presented on the output handshake.
//   ACC_W(n, g) - accumulator width for an n-bit multiplier with g guard bits.
package mult_pkg;
    typedef enum logic {ACCUM, HOLD} state_t;
    function automatic int ACC_W(input int n, input int g);
        return 2 * n + g;
    endfunction
endpackage

// File: rtl/product_accumulator_if.sv
// product_accumulator_if: product input and result output handshakes of the accumulator.
//   in_valid/in_ready/in_p/in_last     - product stream from the multiplier
//   out_valid/out_ready/out_acc/out_count/out_ovf - accumulated result stream
//   slave modport is the accumulator, master modport is its producer/consumer.
interface product_accumulator_if #(parameter int N = 5, parameter int G = 4, parameter int LEN = 4);
    import mult_pkg::*;
    localparam int W = ACC_W(N, G);
    localparam int CW = $clog2(LEN + 1);
    logic                in_valid;
    logic                in_ready;
    logic signed [2*N-1:0] in_p;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_acc;
    logic [CW-1:0]       out_count;
    logic                out_ovf;
    modport slave (input in_valid, in_p, in_last, out_ready, output in_ready, out_valid, out_acc, out_count, out_ovf);
    modport master (output in_valid, in_p, in_last, out_ready, input in_ready, out_valid, out_acc, out_count, out_ovf);
endinterface

// File: rtl/sat_add.sv
// sat_add: combinational signed W-bit add that clamps to the W-bit range.
//   a, b - signed addends; sum - clamped result; ovf - clamp occurred.
module sat_add #(parameter int W = 14) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                ovf
);
    logic signed [W:0] full;
    assign full = {a[W-1], a} + {b[W-1], b};
    // top two bits disagree only when the true sum left the W-bit range; full[W] gives the direction
    assign ovf = full[W] ^ full[W-1];
    assign sum = ovf ? {full[W], {(W-1){~full[W]}}} : full[W-1:0];
endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: saturating signed sum of up to LEN multiplier products per run.
//   clk, rst - clock and synchronous active-high reset
//   bus      - product input and result output handshakes (slave side)
module product_accumulator import mult_pkg::*; #(
    parameter int N = 5,
    parameter int G = 4,
    parameter int LEN = 4
) (
    input logic clk,
    input logic rst,
    product_accumulator_if.slave bus
);
    localparam int W = ACC_W(N, G);
    localparam int CW = $clog2(LEN + 1);
    state_t state, state_n;
    logic signed [W-1:0] acc, acc_n, p_ext, sum;
    logic [CW-1:0] count, count_n;
    logic ovf, ovf_n, sat;
    assign p_ext = {{G{bus.in_p[2*N-1]}}, bus.in_p};
    sat_add #(.W(W)) u_sat (.a(acc), .b(p_ext), .sum(sum), .ovf(sat));
    assign bus.in_ready = (state == ACCUM) | bus.out_ready;
    assign bus.out_valid = state == HOLD;
    assign bus.out_acc = acc;
    assign bus.out_count = count;
    assign bus.out_ovf = ovf;
    always_comb begin
        state_n = state;
        acc_n = acc;
        count_n = count;
        ovf_n = ovf;
        if (state == ACCUM) begin
            if (bus.in_valid) begin
                acc_n = sum;
                count_n = count + CW'(1);
                ovf_n = ovf | sat;
                state_n = (count == CW'(LEN - 1) || bus.in_last) ? HOLD : ACCUM;
            end
        end else if (bus.out_ready) begin
            // a product arriving with the release starts the next run without a bubble
            acc_n = bus.in_valid ? p_ext : '0;
            count_n = bus.in_valid ? CW'(1) : '0;
            ovf_n = 1'b0;
            state_n = (bus.in_valid && (LEN == 1 || bus.in_last)) ? HOLD : ACCUM;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
            acc <= '0;
            count <= '0;
            ovf <= 1'b0;
        end else begin
            state <= state_n;
            acc <= acc_n;
            count <= count_n;
            ovf <= ovf_n;
        end
    end
endmodule
